// File: rtl/sprite_blit.sv
// 8x8 sprite blitter: streams sprite-ROM pixels into the frame buffer,
// skipping transparent pixels and stalling on frame-buffer backpressure.
module sprite_blit #(
  parameter int COLOR_W = 8,
  parameter int ID_W = 4,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [16:0]         coordinates,
  input  logic [ID_W-1:0]     sprite_id,
  output logic                busy,
  output logic                done,
  output logic [16:0]         coords_out,
  output logic [5:0]          counter,
  input  logic [16:0]         pix_addr,
  output logic                rom_en,
  output logic [ID_W+5:0]     rom_addr,
  input  logic [COLOR_W-1:0]  rom_data,
  output logic                fb_we,
  output logic [16:0]         fb_addr,
  output logic [COLOR_W-1:0]  fb_data,
  input  logic                fb_ready
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t state, state_nx;
  logic [ID_W-1:0] id;
  logic s1_valid;
  logic [16:0] s1_addr;
  logic advance, issue, finish;

  assign advance = !(fb_we && !fb_ready);
  assign issue = (state == FETCH) && advance;
  assign finish = (state == DRAIN) && !s1_valid && advance;
  assign rom_en = issue;
  assign rom_addr = {id, counter};

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = FETCH;
      FETCH: if (issue && counter == 6'd63) state_nx = DRAIN;
      DRAIN: if (finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      coords_out <= '0;
      id <= '0;
      counter <= '0;
      s1_valid <= 1'b0;
      s1_addr <= '0;
      fb_we <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      done <= 1'b0;
      state <= state_nx;
      if (state == IDLE && start) begin
        coords_out <= coordinates;
        id <= sprite_id;
        counter <= '0;
        busy <= 1'b1;
      end
      if (issue) begin
        counter <= counter + 6'd1;
        s1_addr <= pix_addr;
      end
      if (advance) s1_valid <= issue;
      // pipeline is empty here, so the write stage just closes out
      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
        fb_we <= 1'b0;
      end else if (advance) begin
        fb_we <= s1_valid && (rom_data != TRANSPARENT);
        fb_addr <= s1_addr;
        fb_data <= rom_data;
      end
    end
  end

endmodule
